// File: rtl/xalu_ise_pkg.sv
// Shared types for the ISE response stage: entry layout, default widths and FSM state encoding.
package xalu_ise_pkg;

    localparam int TAG_W_DEF  = 5;
    localparam int DATA_W_DEF = 64;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [TAG_W_DEF-1:0]  tag;
        logic                  err;
    } ise_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } rsp_state_e;

endpackage

// File: rtl/xalu_ise_rsp_if.sv
// Issue-side request and writeback-side handshake bundle of the ISE response stage.
interface xalu_ise_rsp_if
    import xalu_ise_pkg::*;
#(
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_req;
    logic              in_oval;
    logic [DATA_W-1:0] in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              in_rdy;
    logic              wb_val;
    logic              wb_rdy;
    logic [DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]  wb_tag;
    logic              wb_err;

    // Core side: issues requests and consumes writebacks.
    modport master (
        output in_req, in_oval, in_data, in_tag, wb_rdy,
        input  in_rdy, wb_val, wb_data, wb_tag, wb_err
    );

    // Response stage side.
    modport slave (
        input  in_req, in_oval, in_data, in_tag, wb_rdy,
        output in_rdy, wb_val, wb_data, wb_tag, wb_err
    );
endinterface

// File: rtl/xalu_ise_rsp_fifo.sv
// Generic in-order FIFO: wrap-bit pointers, zero-reset storage, occupancy derived from pointer difference.
module xalu_ise_rsp_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic [CW-1:0]    o_count
);

    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // Each slot resets to zero so a freshly reset stage never exposes stale results.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_mem[gi] <= '0;
                else if (i_push && !i_clr && (r_wr_ptr[AW-1:0] == AW'(gi)))
                    r_mem[gi] <= i_din;
            end
        end
    endgenerate

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    // DEPTH is a power of two, so the wrap-bit difference is the exact occupancy.
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/xalu_ise_rsp.sv
// ISE response stage: captures datapath results/illegal-encoding flags with their tag and returns them in order.
// Optional same-cycle bypass when empty: define XALU_ISE_RSP_BYPASS_EN.
module xalu_ise_rsp
    import xalu_ise_pkg::*;
#(
    parameter  int DEPTH  = 2,
    parameter  int TAG_W  = TAG_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic          ise_clk,
    input  logic          ise_rst,
    input  logic          ise_flush,
    xalu_ise_rsp_if.slave bus,
    output logic [CW-1:0] count
);

    localparam int EW = DATA_W + TAG_W + 1;
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACTIVE = ST_ACTIVE;
    localparam logic [1:0] S_FULL   = ST_FULL;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_in_rdy;
    logic              w_fifo_val;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_in_data;
    logic [EW-1:0]     w_din;
    logic [EW-1:0]     w_dout;
    logic [CW-1:0]     w_count;
    logic              w_wb_val;
    logic [DATA_W-1:0] w_wb_data;
    logic [TAG_W-1:0]  w_wb_tag;
    logic              w_wb_err;

    // Ready and valid decode straight from the state register; no input reaches them combinationally.
    assign w_in_rdy   = (r_state != S_FULL);
    assign w_fifo_val = (r_state != S_IDLE);

    // Illegal encodings carry a zero payload so writeback never sees garbage data.
    assign w_in_data = bus.in_oval ? bus.in_data : '0;
    assign w_din     = {w_in_data, bus.in_tag, !bus.in_oval};

`ifdef XALU_ISE_RSP_BYPASS_EN
    assign w_bypass = !w_fifo_val && bus.wb_rdy && !ise_flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = bus.in_req && w_in_rdy && !ise_flush && !w_bypass;
    assign w_pop  = w_fifo_val && bus.wb_rdy && !ise_flush;

    xalu_ise_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (ise_clk),
        .rst_n   (ise_rst),
        .i_clr   (ise_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_din),
        .o_dout  (w_dout),
        .o_count (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_push) w_state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_push && !w_pop && (w_count == CW'(DEPTH - 1)))
                    w_state_next = S_FULL;
                else if (w_pop && !w_push && (w_count == CW'(1)))
                    w_state_next = S_IDLE;
            end
            S_FULL: begin
                if (w_pop) w_state_next = S_ACTIVE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (ise_flush) w_state_next = S_IDLE;
    end

    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Head fields are gated by valid so an empty stage presents all-zero writeback fields.
    always_comb begin
        w_wb_val  = w_fifo_val;
        w_wb_data = w_fifo_val ? w_dout[EW-1 -: DATA_W] : '0;
        w_wb_tag  = w_fifo_val ? w_dout[TAG_W:1] : '0;
        w_wb_err  = w_fifo_val && w_dout[0];
        if (w_bypass) begin
            w_wb_val  = bus.in_req;
            w_wb_data = bus.in_req ? w_in_data : '0;
            w_wb_tag  = bus.in_req ? bus.in_tag : '0;
            w_wb_err  = bus.in_req && !bus.in_oval;
        end
    end

    assign bus.in_rdy  = w_in_rdy;
    assign bus.wb_val  = w_wb_val;
    assign bus.wb_data = w_wb_data;
    assign bus.wb_tag  = w_wb_tag;
    assign bus.wb_err  = w_wb_err;
    assign count       = w_count;

endmodule

// File: tb/tb_xalu_ise_rsp.sv
// Directed vector table, asynchronous-reset sequence and random queue-model run for xalu_ise_rsp (registered build).
module tb_xalu_ise_rsp;
    import xalu_ise_pkg::*;

    localparam int DEPTH  = 2;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 64;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          ise_clk   = 1'b0;
    logic          ise_rst   = 1'b0;
    logic          ise_flush = 1'b0;
    logic [CW-1:0] count;

    xalu_ise_rsp_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    xalu_ise_rsp #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .ise_clk   (ise_clk),
        .ise_rst   (ise_rst),
        .ise_flush (ise_flush),
        .bus       (bus),
        .count     (count)
    );

    always #5 ise_clk = ~ise_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic oval, input logic [63:0] data,
                         input logic [4:0] tag, input logic rdy, input logic flush);
        bus.in_req  = req;
        bus.in_oval = oval;
        bus.in_data = data;
        bus.in_tag  = tag;
        bus.wb_rdy  = rdy;
        ise_flush   = flush;
    endtask

    task automatic chk_outs(input string pfx, input logic val, input logic [63:0] data,
                            input logic [4:0] tag, input logic err, input logic [CW-1:0] cnt,
                            input logic in_rdy);
        chk({pfx, ".wb_val"},  64'(bus.wb_val),  64'(val));
        chk({pfx, ".wb_data"}, bus.wb_data,      data);
        chk({pfx, ".wb_tag"},  64'(bus.wb_tag),  64'(tag));
        chk({pfx, ".wb_err"},  64'(bus.wb_err),  64'(err));
        chk({pfx, ".count"},   64'(count),       64'(cnt));
        chk({pfx, ".in_rdy"},  64'(bus.in_rdy),  64'(in_rdy));
    endtask

    typedef struct {
        logic          req;
        logic          oval;
        logic [63:0]   data;
        logic [4:0]    tag;
        logic          rdy;
        logic          flush;
        logic          e_val;
        logic [63:0]   e_data;
        logic [4:0]    e_tag;
        logic          e_err;
        logic [CW-1:0] e_cnt;
        logic          e_in_rdy;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ise_entry_t q[$];
        ise_entry_t e;
        logic       m_push, m_pop;

        // inputs -> expected state of wb_*/count/in_rdy just after the edge
        tbl[0]  = '{1, 1, 64'h0123_4567_89AB_CDEF, 5'd7, 1, 0,  1, 64'h0123_4567_89AB_CDEF, 5'd7, 0, 2'd1, 1};
        tbl[1]  = '{1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1, 0,  1, 64'h0, 5'd3, 1, 2'd1, 1};
        tbl[2]  = '{0, 0, 64'h0, 5'd0, 1, 0,                     0, 64'h0, 5'd0, 0, 2'd0, 1};
        tbl[3]  = '{1, 1, 64'h11, 5'd1, 0, 0,                    1, 64'h11, 5'd1, 0, 2'd1, 1};
        tbl[4]  = '{1, 1, 64'h22, 5'd2, 0, 0,                    1, 64'h11, 5'd1, 0, 2'd2, 0};
        tbl[5]  = '{1, 1, 64'h33, 5'd3, 0, 0,                    1, 64'h11, 5'd1, 0, 2'd2, 0};
        tbl[6]  = '{1, 1, 64'h33, 5'd3, 1, 0,                    1, 64'h22, 5'd2, 0, 2'd1, 1};
        tbl[7]  = '{1, 1, 64'h33, 5'd3, 0, 0,                    1, 64'h22, 5'd2, 0, 2'd2, 0};
        tbl[8]  = '{0, 0, 64'h0, 5'd0, 1, 0,                     1, 64'h33, 5'd3, 0, 2'd1, 1};
        tbl[9]  = '{1, 1, 64'h44, 5'd4, 0, 0,                    1, 64'h33, 5'd3, 0, 2'd2, 0};
        tbl[10] = '{1, 1, 64'h55, 5'd5, 1, 1,                    0, 64'h0, 5'd0, 0, 2'd0, 1};
        tbl[11] = '{0, 0, 64'h0, 5'd0, 1, 0,                     0, 64'h0, 5'd0, 0, 2'd0, 1};
        tbl[12] = '{1, 1, 64'h66, 5'd6, 1, 0,                    1, 64'h66, 5'd6, 0, 2'd1, 1};
        tbl[13] = '{1, 1, 64'h77, 5'd8, 1, 0,                    1, 64'h77, 5'd8, 0, 2'd1, 1};
        tbl[14] = '{0, 0, 64'h0, 5'd0, 0, 0,                     1, 64'h77, 5'd8, 0, 2'd1, 1};
        tbl[15] = '{0, 0, 64'h0, 5'd0, 1, 0,                     0, 64'h0, 5'd0, 0, 2'd0, 1};

        drive(0, 0, 64'h0, 5'd0, 0, 0);
        repeat (2) @(posedge ise_clk);
        #1;
        chk_outs("reset", 0, 64'h0, 5'd0, 0, 2'd0, 1);
        $display("reset: wb_val=%0b count=%0d in_rdy=%0b", bus.wb_val, count, bus.in_rdy);
        @(negedge ise_clk);
        ise_rst = 1'b1;
        @(posedge ise_clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].req, tbl[i].oval, tbl[i].data, tbl[i].tag, tbl[i].rdy, tbl[i].flush);
            @(posedge ise_clk);
            #1;
            chk_outs($sformatf("vec%0d", i), tbl[i].e_val, tbl[i].e_data, tbl[i].e_tag,
                     tbl[i].e_err, tbl[i].e_cnt, tbl[i].e_in_rdy);
            $display("vec %0d: req=%0b tag=%0d rdy=%0b flush=%0b -> val=%0b data=%h tag=%0d err=%0b cnt=%0d",
                     i, tbl[i].req, tbl[i].tag, tbl[i].rdy, tbl[i].flush,
                     bus.wb_val, bus.wb_data, bus.wb_tag, bus.wb_err, count);
        end

        // Two held entries, then reset asserted mid-cycle with no clock edge in between.
        drive(1, 1, 64'hAAAA, 5'd10, 0, 0);
        @(posedge ise_clk);
        #1;
        drive(1, 1, 64'hBBBB, 5'd11, 0, 0);
        @(posedge ise_clk);
        #1;
        drive(0, 0, 64'h0, 5'd0, 0, 0);
        chk("arst.pre_count", 64'(count), 64'd2);
        #2;
        ise_rst = 1'b0;
        #1;
        chk_outs("arst", 0, 64'h0, 5'd0, 0, 2'd0, 1);
        $display("async reset: wb_val=%0b count=%0d in_rdy=%0b", bus.wb_val, count, bus.in_rdy);
        #2;
        ise_rst = 1'b1;
        @(posedge ise_clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            // A refused request is held unchanged until the stage accepts it.
            if (!(bus.in_req && q.size() == DEPTH)) begin
                bus.in_req  = ($urandom_range(0, 3) != 0);
                bus.in_oval = ($urandom_range(0, 3) != 0);
                bus.in_data = {$urandom, $urandom};
                bus.in_tag  = 5'($urandom_range(0, 31));
            end
            bus.wb_rdy = ($urandom_range(0, 2) != 0);
            #3;
            chk($sformatf("rnd%0d.wb_val", i), 64'(bus.wb_val), 64'(q.size() != 0));
            chk($sformatf("rnd%0d.count", i),  64'(count),       64'(q.size()));
            chk($sformatf("rnd%0d.in_rdy", i), 64'(bus.in_rdy),  64'(q.size() < DEPTH));
            if (q.size() != 0) begin
                chk($sformatf("rnd%0d.wb_data", i), bus.wb_data,         q[0].data);
                chk($sformatf("rnd%0d.wb_tag", i),  64'(bus.wb_tag),     64'(q[0].tag));
                chk($sformatf("rnd%0d.wb_err", i),  64'(bus.wb_err),     64'(q[0].err));
            end
            m_push = bus.in_req && (q.size() < DEPTH);
            m_pop  = (q.size() != 0) && bus.wb_rdy;
            e.data = bus.in_oval ? bus.in_data : 64'h0;
            e.tag  = bus.in_tag;
            e.err  = !bus.in_oval;
            $display("rnd %0d: req=%0b rdy=%0b push=%0b pop=%0b qsize=%0d count=%0d",
                     i, bus.in_req, bus.wb_rdy, m_push, m_pop, q.size(), count);
            @(posedge ise_clk);
            if (m_pop)  void'(q.pop_front());
            if (m_push) q.push_back(e);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
